// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: shared FPU widths, commands, op classes and return record
package fpu_issue_ctrl_pkg;

    localparam int C_CMD   = 4;
    localparam int C_OP    = 32;
    localparam int C_RM    = 3;
    localparam int C_PC    = 5;
    localparam int C_FFLAG = 5;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
    localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
    localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
    localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
    localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
    localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
    localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
    localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
    localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
    localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
    localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
    localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

    typedef enum logic [1:0] {CLS_NONE, CLS_CORE, CLS_FMA, CLS_DIV} fpu_cls_t;

    typedef struct packed {
        logic [C_OP-1:0]    result;
        logic [C_FFLAG-1:0] flags;
    } fpu_ret_t;

    // Ops of one class share a fixed latency; CLS_NONE marks commands the FPU never sees
    function automatic fpu_cls_t fpu_op_cls(input logic [C_CMD-1:0] op);
        case (op)
            C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
            C_FPU_I2F_CMD, C_FPU_F2I_CMD:                      return CLS_CORE;
            C_FPU_FMADD_CMD, C_FPU_FMSUB_CMD,
            C_FPU_FNMADD_CMD, C_FPU_FNMSUB_CMD:                return CLS_FMA;
            C_FPU_DIV_CMD, C_FPU_SQRT_CMD:                     return CLS_DIV;
            default:                                           return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: synchronous FIFO with occupancy count
module fpu_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop, full;

    assign full   = count == (AW+1)'(DEPTH);
    assign do_pop = pop && count != '0;
    assign rdata  = mem[rd_ptr];

    // Pointers and occupancy; a pop on an empty FIFO is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
        else $error("fpu_issue_fifo: push on full FIFO");

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: in-order issue to the private FPU with tag tracking and buffered responses
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [C_CMD-1:0]    req_op_i,
    input  logic [C_OP-1:0]     req_a_i,
    input  logic [C_OP-1:0]     req_b_i,
    input  logic [C_OP-1:0]     req_c_i,
    input  logic [C_RM-1:0]     req_rm_i,
    input  logic [C_PC-1:0]     req_prec_i,
    input  logic [TAG_W-1:0]    req_tag_i,
    output logic                fpu_en_o,
    output logic [C_CMD-1:0]    fpu_op_o,
    output logic [C_OP-1:0]     fpu_a_o,
    output logic [C_OP-1:0]     fpu_b_o,
    output logic [C_OP-1:0]     fpu_c_o,
    output logic [C_RM-1:0]     fpu_rm_o,
    output logic [C_PC-1:0]     fpu_prec_o,
    input  logic [C_OP-1:0]     fpu_result_i,
    input  logic [C_FFLAG-1:0]  fpu_flags_i,
    input  logic                fpu_valid_i,
    input  logic                fpu_divsqrt_busy_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [C_OP-1:0]     rsp_result_o,
    output logic [C_FFLAG-1:0]  rsp_flags_o,
    output logic [TAG_W-1:0]    rsp_tag_o,
    output logic                idle_o,
    output logic                err_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    typedef struct packed {
        fpu_ret_t          ret;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    fpu_cls_t         cur_cls, req_cls;
    logic [CW-1:0]    inflight, inflight_n, tag_cnt, rsp_cnt;
    logic [CW:0]      used;
    logic             pipe_empty, class_ok, acc, acc_sup, acc_nop;
    logic             tag_empty, fpu_pop, rsp_pop;
    logic [TAG_W-1:0] tag_head;
    rsp_t             rsp_in, rsp_out;

    assign req_cls    = fpu_op_cls(req_op_i);
    assign pipe_empty = inflight == '0 && !fpu_en_o;
    assign used       = (CW+1)'(fpu_en_o) + {1'b0, inflight} + {1'b0, rsp_cnt};
    // Unsupported ops also wait for an empty pipe so their response never collides with an FPU return
    assign class_ok   = req_cls == CLS_DIV  ? pipe_empty && !fpu_divsqrt_busy_i :
                        req_cls == CLS_NONE ? pipe_empty :
                        cur_cls == req_cls || pipe_empty;
    assign req_ready_o = used < CAP && class_ok;
    assign acc        = req_valid_i && req_ready_o;
    assign acc_sup    = acc && req_cls != CLS_NONE;
    assign acc_nop    = acc && req_cls == CLS_NONE;
    assign tag_empty  = tag_cnt == '0;
    assign fpu_pop    = fpu_valid_i && !tag_empty;
    assign inflight_n = inflight + CW'(fpu_en_o) - CW'(fpu_pop);
    assign rsp_valid_o = rsp_cnt != '0;
    assign rsp_pop    = rsp_valid_o && rsp_ready_i;
    assign idle_o     = used == '0;

    assign rsp_in = acc_nop ? {{C_OP{1'b0}}, 1'b1, {(C_FFLAG-1){1'b0}}, req_tag_i}
                            : {fpu_result_i, fpu_flags_i, tag_head};

    assign rsp_result_o = rsp_out.ret.result;
    assign rsp_flags_o  = rsp_out.ret.flags;
    assign rsp_tag_o    = rsp_out.tag;

    // Issue register with operand isolation, in-flight count, class tracking and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpu_en_o   <= 1'b0;
            fpu_op_o   <= '0;
            fpu_a_o    <= '0;
            fpu_b_o    <= '0;
            fpu_c_o    <= '0;
            fpu_rm_o   <= '0;
            fpu_prec_o <= '0;
            inflight   <= '0;
            cur_cls    <= CLS_NONE;
            err_o      <= 1'b0;
        end else begin
            fpu_en_o   <= acc_sup;
            fpu_op_o   <= acc_sup ? req_op_i   : '0;
            fpu_a_o    <= acc_sup ? req_a_i    : '0;
            fpu_b_o    <= acc_sup ? req_b_i    : '0;
            fpu_c_o    <= acc_sup ? req_c_i    : '0;
            fpu_rm_o   <= acc_sup ? req_rm_i   : '0;
            fpu_prec_o <= acc_sup ? req_prec_i : '0;
            inflight   <= inflight_n;
            cur_cls    <= acc_sup ? req_cls : inflight_n == '0 ? CLS_NONE : cur_cls;
            err_o      <= err_o || (fpu_valid_i && tag_empty);
        end
    end

    fpu_issue_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (acc_sup),
        .wdata (req_tag_i),
        .pop   (fpu_pop),
        .rdata (tag_head),
        .count (tag_cnt)
    );

    fpu_issue_fifo #(.W($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fpu_pop || acc_nop),
        .wdata (rsp_in),
        .pop   (rsp_pop),
        .rdata (rsp_out),
        .count (rsp_cnt)
    );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of issue rules, ordering, credits and error handling
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               req_valid_i, req_ready_o;
    logic [C_CMD-1:0]   req_op_i;
    logic [C_OP-1:0]    req_a_i, req_b_i, req_c_i;
    logic [C_RM-1:0]    req_rm_i;
    logic [C_PC-1:0]    req_prec_i;
    logic [4:0]         req_tag_i;
    logic               fpu_en_o;
    logic [C_CMD-1:0]   fpu_op_o;
    logic [C_OP-1:0]    fpu_a_o, fpu_b_o, fpu_c_o;
    logic [C_RM-1:0]    fpu_rm_o;
    logic [C_PC-1:0]    fpu_prec_o;
    logic [C_OP-1:0]    fpu_result_i;
    logic [C_FFLAG-1:0] fpu_flags_i;
    logic               fpu_valid_i, fpu_divsqrt_busy_i;
    logic               rsp_valid_o, rsp_ready_i;
    logic [C_OP-1:0]    rsp_result_o;
    logic [C_FFLAG-1:0] rsp_flags_o;
    logic [4:0]         rsp_tag_o;
    logic               idle_o, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fpu_issue_ctrl #(.DEPTH(4), .TAG_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .req_rm_i(req_rm_i), .req_prec_i(req_prec_i), .req_tag_i(req_tag_i),
        .fpu_en_o(fpu_en_o), .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
        .fpu_c_o(fpu_c_o), .fpu_rm_o(fpu_rm_o), .fpu_prec_o(fpu_prec_o),
        .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i), .fpu_valid_i(fpu_valid_i),
        .fpu_divsqrt_busy_i(fpu_divsqrt_busy_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o), .rsp_tag_o(rsp_tag_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [C_CMD-1:0] op, input logic [4:0] tag, input logic [C_OP-1:0] a);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_tag_i   = tag;
        req_a_i     = a;
        req_b_i     = a + 1;
        req_c_i     = a + 2;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 0; req_op_i = '0; req_a_i = '0; req_b_i = '0; req_c_i = '0;
        req_rm_i = 3'd2; req_prec_i = '0; req_tag_i = '0;
        fpu_result_i = '0; fpu_flags_i = '0; fpu_valid_i = 0; fpu_divsqrt_busy_i = 0;
        rsp_ready_i = 1'b1;
        tick; tick;
        rst_i = 1'b0;
        #1;
        check("reset_idle", idle_o, 1);
        check("reset_ready", req_ready_o, 1);
        check("reset_en", fpu_en_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_err", err_o, 0);

        for (int i = 1; i <= 4; i++) begin
            drive_req(C_FPU_ADD_CMD, 5'(i), 32'(i * 16));
            check($sformatf("add%0d_ready", i), req_ready_o, 1);
            tick;
            check($sformatf("add%0d_en", i), fpu_en_o, 1);
            check($sformatf("add%0d_a", i), fpu_a_o, 64'(i * 16));
        end
        req_valid_i = 0;
        tick;
        check("add_en_drop", fpu_en_o, 0);
        check("add_isolation", fpu_a_o, 0);
        for (int i = 1; i <= 4; i++) begin
            fpu_valid_i = 1; fpu_result_i = 32'(100 + i); fpu_flags_i = 5'h01;
            tick;
            check($sformatf("add%0d_rsp_valid", i), rsp_valid_o, 1);
            check($sformatf("add%0d_rsp_tag", i), rsp_tag_o, 64'(i));
            check($sformatf("add%0d_rsp_result", i), rsp_result_o, 64'(100 + i));
        end
        fpu_valid_i = 0;
        tick;
        check("add_drained", rsp_valid_o, 0);
        check("add_idle", idle_o, 1);

        drive_req(C_FPU_ADD_CMD, 5'd7, 32'h70);
        check("add7_ready", req_ready_o, 1);
        tick;
        drive_req(C_FPU_FMADD_CMD, 5'd8, 32'h80);
        check("fma_blocked_issue", req_ready_o, 0);
        tick;
        check("fma_blocked_inflight", req_ready_o, 0);
        fpu_valid_i = 1; fpu_result_i = 32'd7; fpu_flags_i = '0;
        #1;
        check("fma_blocked_return", req_ready_o, 0);
        tick;
        fpu_valid_i = 0;
        #1;
        check("fma_ready_after", req_ready_o, 1);
        check("rsp7_tag", rsp_tag_o, 7);
        tick;
        req_valid_i = 0;
        check("fma_en", fpu_en_o, 1);
        check("fma_op", fpu_op_o, 64'(C_FPU_FMADD_CMD));
        fpu_valid_i = 1; fpu_result_i = 32'd8;
        tick;
        fpu_valid_i = 0;
        check("rsp8_valid", rsp_valid_o, 1);
        check("rsp8_tag", rsp_tag_o, 8);
        check("rsp8_result", rsp_result_o, 8);
        tick;
        check("fma_idle", idle_o, 1);

        fpu_divsqrt_busy_i = 1;
        req_prec_i = 5'h15;
        drive_req(C_FPU_DIV_CMD, 5'd9, 32'h90);
        check("div_busy_ready", req_ready_o, 0);
        tick;
        check("div_busy_no_en", fpu_en_o, 0);
        fpu_divsqrt_busy_i = 0;
        #1;
        check("div_free_ready", req_ready_o, 1);
        tick;
        req_valid_i = 0;
        check("div_en", fpu_en_o, 1);
        check("div_op", fpu_op_o, 64'(C_FPU_DIV_CMD));
        check("div_prec", fpu_prec_o, 5'h15);
        check("div_rm", fpu_rm_o, 3'd2);
        tick;
        fpu_valid_i = 1; fpu_result_i = 32'd9;
        tick;
        fpu_valid_i = 0;
        check("div_rsp_tag", rsp_tag_o, 9);
        tick;

        rsp_ready_i = 0;
        for (int i = 1; i <= 4; i++) begin
            drive_req(C_FPU_MUL_CMD, 5'(10 + i), 32'h100);
            check($sformatf("mul%0d_ready", i), req_ready_o, 1);
            tick;
        end
        drive_req(C_FPU_MUL_CMD, 5'd15, 32'h200);
        check("mul5_no_credit", req_ready_o, 0);
        for (int i = 1; i <= 4; i++) begin
            fpu_valid_i = 1; fpu_result_i = 32'(200 + i);
            tick;
        end
        fpu_valid_i = 0;
        #1;
        check("mul_full_ready", req_ready_o, 0);
        check("mul_stall_valid", rsp_valid_o, 1);
        check("mul_stall_tag", rsp_tag_o, 11);
        check("mul_stall_result", rsp_result_o, 201);
        rsp_ready_i = 1;
        tick;
        rsp_ready_i = 0;
        #1;
        check("mul_one_credit", req_ready_o, 1);
        check("mul_head_after_pop", rsp_tag_o, 12);
        tick;
        req_valid_i = 0;
        #1;
        check("mul5_en", fpu_en_o, 1);
        check("mul_credit_used", req_ready_o, 0);
        fpu_valid_i = 1; fpu_result_i = 32'd215;
        tick;
        fpu_valid_i = 0;
        rsp_ready_i = 1;
        for (int i = 12; i <= 15; i++) begin
            #1;
            check($sformatf("mul_drain_tag%0d", i), rsp_tag_o, 64'(i));
            tick;
        end
        check("mul_drain_empty", rsp_valid_o, 0);
        check("mul_idle", idle_o, 1);

        fpu_valid_i = 1; fpu_result_i = 32'hDEAD;
        tick;
        fpu_valid_i = 0;
        check("stray_err", err_o, 1);
        check("stray_no_rsp", rsp_valid_o, 0);
        tick;
        check("stray_err_sticky", err_o, 1);

        drive_req(C_FPU_NOP_CMD, 5'd3, 32'h33);
        check("nop_ready", req_ready_o, 1);
        tick;
        req_valid_i = 0;
        check("nop_no_en", fpu_en_o, 0);
        check("nop_rsp_valid", rsp_valid_o, 1);
        check("nop_flags", rsp_flags_o, 5'b10000);
        check("nop_result", rsp_result_o, 0);
        check("nop_tag", rsp_tag_o, 3);
        tick;
        check("nop_idle", idle_o, 1);

        drive_req(C_FPU_SUB_CMD, 5'd4, 32'h44);
        tick;
        req_valid_i = 0;
        check("pre_reset_en", fpu_en_o, 1);
        rst_i = 1;
        #1;
        check("midreset_en", fpu_en_o, 0);
        check("midreset_idle", idle_o, 1);
        check("midreset_err", err_o, 0);
        tick;
        rst_i = 0;
        #1;
        check("post_reset_ready", req_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
